fir_tdm_ctrl: RTL and testbench
===============================

# fir_tdm_ctrl

Time-multiplexed FIR tap sequencer and accumulator that drives a single external pipelined multiply-add unit in the FIR datapath. It sits directly upstream and downstream of that unit: it stores input samples in a circular delay line, issues one (sample, coefficient) pair per cycle, and accumulates the returned products. It then rounds, optionally saturates, and emits one filtered output per accepted input sample.

## Interface
- DATA_WDTH, 16, signed input sample width
- COEF_WDTH, 16, signed coefficient width
- TAP_NUM, 16, number of taps (≥2, power of two)
- MAC_DELAY, 1, pipeline latency of the attached MAC in cycles (≥0)
- OUT_WDTH, 16, signed output width
- OUT_SHIFT, 15, right shift applied after accumulation (≥1)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: zero delay line, abort current sample
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_WDTH  signed sample
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  clog2(TAP_NUM)  tap index
- coef_wr_data  in  COEF_WDTH  signed coefficient
- coef_wr_err  out  1  one-cycle pulse: write dropped (block busy)
- mac_a  out  DATA_WDTH  sample operand to MAC
- mac_b  out  COEF_WDTH  coefficient operand to MAC
- mac_c  out  DATA_WDTH+COEF_WDTH  addend to MAC, held at 0
- mac_sum  in  DATA_WDTH+COEF_WDTH  MAC result, MAC_DELAY cycles after operands
- out_valid  out  1  one-cycle output strobe
- out_data  out  OUT_WDTH  filtered sample

## Operation
- Reset: all outputs 0 except in_ready=1. Delay line and coefficient registers are 0. State is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, write in_data at wr_ptr and go to RUN.
  - RUN: issue TAP_NUM taps. Tap k uses sample[(wr_ptr−k) mod TAP_NUM] and coef[k]. After tap TAP_NUM−1, go to DRAIN.
  - DRAIN: wait for the remaining MAC_DELAY results. On the last result, latch the output, advance wr_ptr and go to IDLE.
- in_ready=0 in RUN and DRAIN. in_valid is ignored while not ready.
- Tag pipeline: MAC_DELAY-deep shift register of {tap_valid, tap_first, tap_last}, aligned with mac_sum.
- Accumulator: ACC_WDTH = DATA_WDTH+COEF_WDTH+clog2(TAP_NUM). mac_sum is sign-extended.
  - On tap_first: acc = sum.
  - Otherwise: acc = acc + sum.
- Output on tap_last: r = (acc_final + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT, arithmetic shift, round half up. r is then reduced to OUT_WDTH (see Configuration).
- Outside RUN, mac_a and mac_b are driven to 0.
- Coefficient writes:
  - Accepted only in IDLE; the write occurs the same edge.
  - In RUN or DRAIN the write is dropped and coef_wr_err pulses on the next cycle.
  - A write in IDLE coinciding with an accepted sample is applied before that sample's taps.
- clr:
  - Has priority over everything else.
  - Next cycle: state IDLE, delay line zeroed, wr_ptr=0, tag pipeline cleared, no out_valid for the aborted sample.
  - Coefficients are retained.
- wr_ptr wraps TAP_NUM−1 → 0.

## Timing
- Sample accepted at cycle 0 (in_valid && in_ready).
- Tap k is on mac_a/mac_b during cycle k+1, with registered outputs.
- The mac_sum for tap k is sampled in cycle k+1+MAC_DELAY.
- out_valid and out_data are valid in cycle TAP_NUM+MAC_DELAY+1.
- in_ready returns high in that same cycle, giving a back-to-back accept period of TAP_NUM+MAC_DELAY+1 cycles.
- MAC_DELAY=0 is legal: mac_sum is combinational and DRAIN is skipped.
- out_data holds its value until the next out_valid.

## Configuration
- FIR_SAT_EN defined: r is clamped to [−2^(OUT_WDTH−1), 2^(OUT_WDTH−1)−1].
- FIR_SAT_EN undefined: r is truncated to its low OUT_WDTH bits (two's-complement wrap). No saturation logic is built.

## Structure
- Shared package fir_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - clog2 function and ACC_WDTH derivation
  - rounding-constant helper
- Sub-module fir_round_sat: combinational round/shift/saturate, under FIR_SAT_EN. Registered in the parent.
- The MAC is external and connected in the parent FIR wrapper.

## Test plan
Bench parameters: TAP_NUM=4, MAC_DELAY=1, OUT_SHIFT=2, DATA_WDTH=OUT_WDTH=16, with a behavioural MAC model attached.
- Coefs {1,2,3,4}, inputs 4,0,0,0,0 → outputs 1,2,3,4,0.
- Rounding, coefs {1,0,0,0}:
  - input 2 → 1
  - input −2 → 0
  - input 6 → 2
  - input −7 → −2
- Latency: accept at cycle 0 → out_valid exactly in cycle 6 and in_ready high in cycle 6.
- Saturation, coefs all 0x7FFF, four inputs of 0x7FFF:
  - FIR_SAT_EN defined → 0x7FFF.
  - FIR_SAT_EN undefined → low 16 bits of (4·0x7FFF²+2)>>>2.
- Coefficient write during RUN → coef_wr_err pulses once and the coefficient is unchanged; rerunning the impulse gives the same result.
- clr asserted in cycle 2 of RUN → no out_valid and in_ready=1 next cycle. The following impulse yields outputs from a zeroed delay line.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR tap sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Travels alongside each tap so the accumulator knows how to treat mac_sum.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  function automatic int f_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int f_acc_wdth(input int dw, input int cw, input int tn);
    return dw + cw + f_clog2(tn);
  endfunction

  function automatic longint f_round_const(input int shift);
    return longint'(1) << (shift - 1);
  endfunction

endpackage

// File: rtl/fir_tdm_ctrl_if.sv
// Sample, coefficient, MAC and output signals of fir_tdm_ctrl.
// Handshake: a sample transfers on a rising edge where in_valid && in_ready;
// in_valid is ignored while in_ready is low, and out_valid is a one-cycle strobe.
interface fir_tdm_ctrl_if #(
  parameter int DATA_WDTH = 16,
  parameter int COEF_WDTH = 16,
  parameter int TAP_NUM   = 16,
  parameter int OUT_WDTH  = 16
);
  localparam int AW = fir_pkg::f_clog2(TAP_NUM);
  localparam int PW = DATA_WDTH + COEF_WDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_WDTH-1:0] in_data;
  logic                 coef_wr_en;
  logic [AW-1:0]        coef_wr_addr;
  logic [COEF_WDTH-1:0] coef_wr_data;
  logic                 coef_wr_err;
  logic [DATA_WDTH-1:0] mac_a;
  logic [COEF_WDTH-1:0] mac_b;
  logic [PW-1:0]        mac_c;
  logic [PW-1:0]        mac_sum;
  logic                 out_valid;
  logic [OUT_WDTH-1:0]  out_data;
  fir_pkg::state_t      dbg_state;

  modport master (
    output in_valid, in_data, coef_wr_en, coef_wr_addr, coef_wr_data, mac_sum,
    input  in_ready, coef_wr_err, mac_a, mac_b, mac_c, out_valid, out_data, dbg_state
  );

  modport slave (
    input  in_valid, in_data, coef_wr_en, coef_wr_addr, coef_wr_data, mac_sum,
    output in_ready, coef_wr_err, mac_a, mac_b, mac_c, out_valid, out_data, dbg_state
  );

endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and width reduction.
// Define FIR_SAT_EN to clamp to the output range instead of wrapping.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_WDTH  = 36,
  parameter int OUT_WDTH  = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic signed [ACC_WDTH-1:0] i_acc,
  output logic        [OUT_WDTH-1:0] o_data
);
  localparam int EW = ACC_WDTH + 1;

  // One guard bit so the rounding bias can never overflow the accumulator.
  logic signed [EW-1:0] w_biased;
  assign w_biased = EW'(i_acc) + EW'(f_round_const(OUT_SHIFT));

`ifdef FIR_SAT_EN
  logic signed [EW-1:0] w_shifted;
  logic                 w_ovf;

  assign w_shifted = w_biased >>> OUT_SHIFT;
  // In range only when every bit above the output sign bit matches it.
  assign w_ovf = !((&w_shifted[EW-1:OUT_WDTH-1]) || (~|w_shifted[EW-1:OUT_WDTH-1]));

  always_comb begin
    o_data = w_shifted[OUT_WDTH-1:0];
    if (w_ovf) begin
      o_data = w_shifted[EW-1] ? {1'b1, {(OUT_WDTH-1){1'b0}}}
                               : {1'b0, {(OUT_WDTH-1){1'b1}}};
    end
  end
`else
  assign o_data = OUT_WDTH'(w_biased >>> OUT_SHIFT);
`endif

endmodule

// File: rtl/fir_tdm_ctrl.sv
// Time-multiplexed FIR tap sequencer/accumulator driving one external pipelined MAC.
// Build option: FIR_SAT_EN selects output saturation (default wraps).
module fir_tdm_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_WDTH = 16,
  parameter int COEF_WDTH = 16,
  parameter int TAP_NUM   = 16,
  parameter int MAC_DELAY = 1,
  parameter int OUT_WDTH  = 16,
  parameter int OUT_SHIFT = 15
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clr,
  fir_tdm_ctrl_if.slave bus
);
  localparam int AW       = f_clog2(TAP_NUM);
  localparam int PW       = DATA_WDTH + COEF_WDTH;
  localparam int ACC_WDTH = f_acc_wdth(DATA_WDTH, COEF_WDTH, TAP_NUM);

  state_t                      r_state;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_tap_cnt;
  logic                        r_in_ready;
  logic [DATA_WDTH-1:0]        r_mac_a;
  logic [COEF_WDTH-1:0]        r_mac_b;
  tag_t                        r_tag0;
  logic signed [ACC_WDTH-1:0]  r_acc;
  logic                        r_out_valid;
  logic [OUT_WDTH-1:0]         r_out_data;
  logic                        r_coef_wr_err;
  logic [DATA_WDTH-1:0]        r_dline [TAP_NUM];
  logic [COEF_WDTH-1:0]        r_coef  [TAP_NUM];

  tag_t                        w_tag;
  logic [AW-1:0]               w_tap_nxt;
  logic [AW-1:0]               w_rd_idx;
  logic signed [ACC_WDTH-1:0]  w_sum_ext;
  logic signed [ACC_WDTH-1:0]  w_acc_next;
  logic [OUT_WDTH-1:0]         w_rounded;

  assign w_tap_nxt  = r_tap_cnt + AW'(1);
  assign w_rd_idx   = r_wr_ptr - w_tap_nxt;
  assign w_sum_ext  = {{(ACC_WDTH-PW){bus.mac_sum[PW-1]}}, bus.mac_sum};
  assign w_acc_next = w_tag.first ? w_sum_ext : (r_acc + w_sum_ext);

  // r_tag0 describes the tap on mac_a/mac_b; w_tag is it delayed to line up with mac_sum.
  generate
    if (MAC_DELAY == 0) begin : g_nodly
      assign w_tag = r_tag0;
    end else begin : g_dly
      tag_t r_pipe [MAC_DELAY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MAC_DELAY; i++) r_pipe[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < MAC_DELAY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= r_tag0;
          for (int i = 1; i < MAC_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_tag = r_pipe[MAC_DELAY-1];
    end
  endgenerate

  fir_round_sat #(
    .ACC_WDTH (ACC_WDTH),
    .OUT_WDTH (OUT_WDTH),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .i_acc (w_acc_next),
    .o_data(w_rounded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_tap_cnt     <= '0;
      r_in_ready    <= 1'b1;
      r_mac_a       <= '0;
      r_mac_b       <= '0;
      r_tag0        <= '0;
      r_acc         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_coef_wr_err <= 1'b0;
      for (int i = 0; i < TAP_NUM; i++) begin
        r_dline[i] <= '0;
        r_coef[i]  <= '0;
      end
    end else begin
      r_out_valid   <= 1'b0;
      r_coef_wr_err <= 1'b0;
      if (clr) begin
        r_state    <= IDLE;
        r_wr_ptr   <= '0;
        r_tap_cnt  <= '0;
        r_in_ready <= 1'b1;
        r_mac_a    <= '0;
        r_mac_b    <= '0;
        r_tag0     <= '0;
        for (int i = 0; i < TAP_NUM; i++) r_dline[i] <= '0;
      end else begin
        if (w_tag.vld) r_acc <= w_acc_next;
        if (w_tag.vld && w_tag.last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_rounded;
        end
        case (r_state)
          IDLE: begin
            if (bus.coef_wr_en) r_coef[bus.coef_wr_addr] <= bus.coef_wr_data;
            if (bus.in_valid) begin
              r_dline[r_wr_ptr] <= bus.in_data;
              // Tap 0 is the new sample; a same-edge write to coef[0] must win.
              r_mac_a    <= bus.in_data;
              r_mac_b    <= (bus.coef_wr_en && (bus.coef_wr_addr == '0)) ? bus.coef_wr_data
                                                                          : r_coef[0];
              r_tag0     <= '{vld: 1'b1, first: 1'b1, last: 1'b0};
              r_tap_cnt  <= '0;
              r_in_ready <= 1'b0;
              r_state    <= RUN;
            end
          end
          RUN: begin
            if (bus.coef_wr_en) r_coef_wr_err <= 1'b1;
            if (r_tap_cnt == AW'(TAP_NUM - 1)) begin
              r_mac_a <= '0;
              r_mac_b <= '0;
              r_tag0  <= '0;
              // With a combinational MAC the last product is already being accumulated.
              if (w_tag.vld && w_tag.last) begin
                r_state    <= IDLE;
                r_in_ready <= 1'b1;
                r_wr_ptr   <= r_wr_ptr + AW'(1);
              end else begin
                r_state <= DRAIN;
              end
            end else begin
              r_mac_a   <= r_dline[w_rd_idx];
              r_mac_b   <= r_coef[w_tap_nxt];
              r_tag0    <= '{vld: 1'b1, first: 1'b0, last: (w_tap_nxt == AW'(TAP_NUM - 1))};
              r_tap_cnt <= w_tap_nxt;
            end
          end
          DRAIN: begin
            if (bus.coef_wr_en) r_coef_wr_err <= 1'b1;
            if (w_tag.vld && w_tag.last) begin
              r_state    <= IDLE;
              r_in_ready <= 1'b1;
              r_wr_ptr   <= r_wr_ptr + AW'(1);
            end
          end
          default: begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.coef_wr_err = r_coef_wr_err;
  assign bus.mac_a       = r_mac_a;
  assign bus.mac_b       = r_mac_b;
  assign bus.mac_c       = '0;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// Bench for fir_tdm_ctrl: 4 taps, one-cycle behavioural MAC, shift of 2.
module tb_fir_tdm_ctrl;
  import fir_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int TN  = 4;
  localparam int MD  = 1;
  localparam int OW  = 16;
  localparam int SH  = 2;

  logic clk;
  logic rst_n;
  logic clr;

  fir_tdm_ctrl_if #(.DATA_WDTH(DW), .COEF_WDTH(CW), .TAP_NUM(TN), .OUT_WDTH(OW)) bus ();

  fir_tdm_ctrl #(
    .DATA_WDTH(DW), .COEF_WDTH(CW), .TAP_NUM(TN),
    .MAC_DELAY(MD), .OUT_WDTH(OW), .OUT_SHIFT(SH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural MAC, one cycle of latency ----------------
  logic signed [DW+CW-1:0] mac_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_pipe <= '0;
    else        mac_pipe <= $signed(bus.mac_a) * $signed(bus.mac_b) + $signed(bus.mac_c);
  end
  assign bus.mac_sum = mac_pipe;

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mon_exp;
  int n_cmp;
  int n_err;
  int err_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.coef_wr_err) err_cnt++;
      if (rst_n && bus.out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got 0x%0h, required no output", bus.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.out_data !== mon_exp) begin
            n_err++;
            $display("FAIL out_data: got 0x%0h, required 0x%0h", bus.out_data, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit push, input logic [OW-1:0] e);
    wait_ready();
    if (push) exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [CW-1:0] d);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = a;
    bus.coef_wr_data = d;
    @(negedge clk);
    bus.coef_wr_en   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int early_valid;
    int early_ready;
    int err_before;
    int t;
    n_cmp = 0;
    n_err = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.coef_wr_en = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_mac_a", 32'(bus.mac_a), 32'd0);
    chk("rst_mac_b", 32'(bus.mac_b), 32'd0);
    chk("rst_mac_c", 32'(bus.mac_c), 32'd0);
    chk("rst_coef_err", 32'(bus.coef_wr_err), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse through coefs {1,2,3,4}.
    wr_coef(2'd0, 16'd1);
    wr_coef(2'd1, 16'd2);
    wr_coef(2'd2, 16'd3);
    wr_coef(2'd3, 16'd4);
    send(16'd4, 1, 16'd1);
    send(16'd0, 1, 16'd2);
    send(16'd0, 1, 16'd3);
    send(16'd0, 1, 16'd4);
    send(16'd0, 1, 16'd0);

    // Rounding with coef[0] written in the same cycle as the first sample.
    wait_ready();
    wr_coef(2'd0, 16'd0);
    wr_coef(2'd1, 16'd0);
    wr_coef(2'd2, 16'd0);
    wr_coef(2'd3, 16'd0);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 2'd0;
    bus.coef_wr_data = 16'd1;
    send(16'd2, 1, 16'd1);
    bus.coef_wr_en   = 1'b0;
    send(16'hFFFE, 1, 16'd0);
    send(16'd6, 1, 16'd2);
    send(16'hFFF9, 1, 16'hFFFE);

    // Latency: accept in cycle 0, output and in_ready in cycle 6.
    wait_ready();
    exp_q.push_back(16'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd8;
    early_valid = 0;
    early_ready = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (c == 1) begin
        chk("tap0_mac_a", 32'(bus.mac_a), 32'd8);
        chk("tap0_mac_b", 32'(bus.mac_b), 32'd1);
        chk("run_state", 32'(bus.dbg_state), 32'(RUN));
      end
      if (c == 5) begin
        chk("drain_mac_a", 32'(bus.mac_a), 32'd0);
        chk("drain_state", 32'(bus.dbg_state), 32'(DRAIN));
      end
      if (c < 6) begin
        if (bus.out_valid) early_valid++;
        if (bus.in_ready) early_ready++;
      end else begin
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
      end
    end
    chk("lat_early_valid", 32'(early_valid), 32'd0);
    chk("lat_early_ready", 32'(early_ready), 32'd0);

    // Coefficient write during RUN is dropped and flagged once.
    pulse_clr();
    wr_coef(2'd0, 16'd1);
    wr_coef(2'd1, 16'd2);
    wr_coef(2'd2, 16'd3);
    wr_coef(2'd3, 16'd4);
    err_before = err_cnt;
    send(16'd4, 1, 16'd1);
    @(negedge clk);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 2'd1;
    bus.coef_wr_data = 16'd100;
    @(negedge clk);
    bus.coef_wr_en   = 1'b0;
    chk("wr_err_pulse", 32'(bus.coef_wr_err), 32'd1);
    @(negedge clk);
    chk("wr_err_clear", 32'(bus.coef_wr_err), 32'd0);
    send(16'd0, 1, 16'd2);
    send(16'd0, 1, 16'd3);
    send(16'd0, 1, 16'd4);
    wait_ready();
    chk("wr_err_count", 32'(err_cnt - err_before), 32'd1);

    // clr in cycle 2 of RUN aborts the sample and zeroes history.
    send(16'd5, 0, 16'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("clr_mac_a", 32'(bus.mac_a), 32'd0);
    repeat (10) @(negedge clk);
    send(16'd4, 1, 16'd1);
    send(16'd0, 1, 16'd2);
    send(16'd0, 1, 16'd3);
    send(16'd0, 1, 16'd4);

    // Full-scale accumulation: saturate or wrap depending on build.
    wait_ready();
    pulse_clr();
    wr_coef(2'd0, 16'h7FFF);
    wr_coef(2'd1, 16'h7FFF);
    wr_coef(2'd2, 16'h7FFF);
    wr_coef(2'd3, 16'h7FFF);
`ifdef FIR_SAT_EN
    send(16'h7FFF, 1, 16'h7FFF);
    send(16'h7FFF, 1, 16'h7FFF);
    send(16'h7FFF, 1, 16'h7FFF);
    send(16'h7FFF, 1, 16'h7FFF);
`else
    send(16'h7FFF, 1, 16'hC000);
    send(16'h7FFF, 1, 16'h8001);
    send(16'h7FFF, 1, 16'h4001);
    send(16'h7FFF, 1, 16'h0001);
`endif

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
